// File: rtl/lock_reg_programmer_pkg.sv
// Shared types and constants for the lock register programmer: FSM states,
// response status codes and the default data width.
package lock_prog_pkg;

  localparam int DW = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    VERIFY = 3'd2,
    LOCK   = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam logic [1:0] ST_OK     = 2'b00;
  localparam logic [1:0] ST_LOCKED = 2'b01;
  localparam logic [1:0] ST_VFAIL  = 2'b10;

endpackage

// File: rtl/lock_reg_programmer.sv
// Programs one of two lockable registers, reads the value back to verify it,
// and optionally locks the register. Locks are one-way until reset.
module lock_reg_programmer
  import lock_prog_pkg::*;
#(
  parameter int DW = lock_prog_pkg::DW
) (
  input  logic          Clk,
  input  logic          resetn,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_sel,
  input  logic [DW-1:0] req_data,
  input  logic          req_lock,
  output logic [DW-1:0] Data_in_1,
  output logic [DW-1:0] Data_in_2,
  output logic          write_1,
  output logic          write_2,
  output logic          Lock_1,
  output logic          Lock_2,
  input  logic [DW-1:0] Data_out_1,
  input  logic [DW-1:0] Data_out_2,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [1:0]    rsp_status,
  output logic [1:0]    locked_mask
);

  // Handshakes: a transfer happens on the rising edge where valid & ready are
  // both high; valid never waits for ready, and the payload is held stable
  // while valid is high and ready is low.

  state_t        state;
  state_t        state_nxt;
  logic          sel_q;
  logic [DW-1:0] data_q;
  logic          lock_q;
  logic [DW-1:0] readback;
  logic          verify_ok;
  logic          accept;
  logic          reject;

  assign accept    = req_valid && (state == IDLE);
  assign reject    = accept && locked_mask[req_sel];
  assign readback  = sel_q ? Data_out_2 : Data_out_1;
  assign verify_ok = (readback == data_q);

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt = locked_mask[req_sel] ? RESP : WRITE;
        end
      end
      WRITE:   state_nxt = VERIFY;
      VERIFY:  state_nxt = (verify_ok && lock_q) ? LOCK : RESP;
      LOCK:    state_nxt = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes decode straight from state so an asynchronous reset drops them at once.
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    write_1   = (state == WRITE) && !sel_q;
    write_2   = (state == WRITE) &&  sel_q;
    Lock_1    = (state == LOCK)  && !sel_q;
    Lock_2    = (state == LOCK)  &&  sel_q;
  end

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      sel_q       <= 1'b0;
      data_q      <= '0;
      lock_q      <= 1'b0;
      Data_in_1   <= '0;
      Data_in_2   <= '0;
      locked_mask <= 2'b00;
      rsp_status  <= ST_OK;
    end else begin
      if (accept) begin
        sel_q  <= req_sel;
        data_q <= req_data;
        lock_q <= req_lock;
        if (reject) begin
          rsp_status <= ST_LOCKED;
        end else if (req_sel) begin
          Data_in_2 <= req_data;
        end else begin
          Data_in_1 <= req_data;
        end
      end
      if (state == VERIFY) begin
        if (!verify_ok) begin
          rsp_status <= ST_VFAIL;
        end else if (!lock_q) begin
          rsp_status <= ST_OK;
        end
      end
      if (state == LOCK) begin
        locked_mask[sel_q] <= 1'b1;
        rsp_status         <= ST_OK;
      end
    end
  end

endmodule

// File: tb/tb_lock_reg_programmer.sv
// Self-checking bench for lock_reg_programmer: directed scenarios plus random
// transactions checked against a transaction-level model of the register bank.
module tb_lock_reg_programmer;

  logic        Clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic        req_sel;
  logic [15:0] req_data;
  logic        req_lock;
  logic [15:0] Data_in_1, Data_in_2;
  logic        write_1, write_2, Lock_1, Lock_2;
  logic [15:0] Data_out_1, Data_out_2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_status;
  logic [1:0]  locked_mask;

  always #5 Clk = ~Clk;

  lock_reg_programmer #(.DW(16)) dut (
    .Clk(Clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_data(req_data), .req_lock(req_lock),
    .Data_in_1(Data_in_1), .Data_in_2(Data_in_2),
    .write_1(write_1), .write_2(write_2), .Lock_1(Lock_1), .Lock_2(Lock_2),
    .Data_out_1(Data_out_1), .Data_out_2(Data_out_2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .locked_mask(locked_mask)
  );

  // External register bank; ignore_w1 models a register 1 that refuses writes and reads zero.
  logic [15:0] bank [2] = '{16'h0000, 16'h0000};
  logic        ignore_w1 = 1'b0;
  always @(posedge Clk) begin
    if (write_1 && !ignore_w1) bank[0] <= Data_in_1;
    if (write_2) bank[1] <= Data_in_2;
  end
  assign Data_out_1 = ignore_w1 ? 16'h0000 : bank[0];
  assign Data_out_2 = bank[1];

  int total = 0;
  int bad   = 0;

  logic        m_locked [2];
  logic [15:0] m_data_in [2];

  int          n_w_sel, n_w_oth, n_l_sel, n_l_oth, n_multi;
  logic        cur_sel;
  logic [15:0] cur_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_locked[i]  = 1'b0;
      m_data_in[i] = 16'h0000;
    end
  endtask

  task automatic sample_strobes();
    int hi;
    hi = int'(write_1) + int'(write_2) + int'(Lock_1) + int'(Lock_2);
    if (hi > 1) n_multi++;
    if (cur_sel ? write_2 : write_1) begin
      n_w_sel++;
      check("data_in_at_write", cur_sel ? Data_in_2 : Data_in_1, cur_data);
    end
    if (cur_sel ? write_1 : write_2) n_w_oth++;
    if (cur_sel ? Lock_2 : Lock_1) n_l_sel++;
    if (cur_sel ? Lock_1 : Lock_2) n_l_oth++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_strobes"}, {write_1, write_2, Lock_1, Lock_2}, 0);
    check({tag, "_locked_mask"}, locked_mask, 0);
    check({tag, "_data_in_1"}, Data_in_1, 0);
    check({tag, "_data_in_2"}, Data_in_2, 0);
    check({tag, "_rsp_status"}, rsp_status, 0);
  endtask

  // Called at #1 after a rising edge with the DUT idle; returns in the same phase.
  task automatic do_req(input logic sel, input logic [15:0] data, input logic lock,
                        input int hold, input logic early, input logic pulse_busy);
    int          exp_lat, exp_w, exp_l, lat;
    logic [1:0]  exp_st;
    logic [15:0] rb;
    if (m_locked[sel]) begin
      exp_st = 2'b01; exp_lat = 1; exp_w = 0; exp_l = 0;
    end else begin
      m_data_in[sel] = data;
      rb = (!sel && ignore_w1) ? 16'h0000 : data;
      exp_w = 1;
      if (rb != data) begin
        exp_st = 2'b10; exp_lat = 3; exp_l = 0;
      end else if (lock) begin
        exp_st = 2'b00; exp_lat = 4; exp_l = 1;
        m_locked[sel] = 1'b1;
      end else begin
        exp_st = 2'b00; exp_lat = 3; exp_l = 0;
      end
    end
    n_w_sel = 0; n_w_oth = 0; n_l_sel = 0; n_l_oth = 0; n_multi = 0;
    cur_sel = sel; cur_data = data;
    check("req_ready_idle", req_ready, 1);
    req_sel = sel; req_data = data; req_lock = lock; req_valid = 1'b1;
    rsp_ready = early;
    @(posedge Clk); #1;
    req_valid = 1'b0;
    req_data  = $urandom;
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      sample_strobes();
      if (rsp_valid) begin
        lat = c;
        break;
      end
      @(posedge Clk); #1;
    end
    check("latency", lat, exp_lat);
    check("rsp_status", rsp_status, exp_st);
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        check("hold_rsp_valid", rsp_valid, 1);
        check("hold_rsp_status", rsp_status, exp_st);
        check("hold_req_ready", req_ready, 0);
        if (pulse_busy && h == 1) begin
          req_sel = ~sel; req_data = ~data; req_lock = 1'b1; req_valid = 1'b1;
        end
        @(posedge Clk); #1;
        req_valid = 1'b0;
        sample_strobes();
      end
      rsp_ready = 1'b1;
    end
    @(posedge Clk); #1;
    rsp_ready = 1'b0;
    sample_strobes();
    check("rsp_done_valid", rsp_valid, 0);
    check("rsp_done_ready", req_ready, 1);
    check("write_sel_count", n_w_sel, exp_w);
    check("lock_sel_count", n_l_sel, exp_l);
    check("other_strobes", n_w_oth + n_l_oth, 0);
    check("one_hot_strobes", n_multi, 0);
    check("data_in_1", Data_in_1, m_data_in[0]);
    check("data_in_2", Data_in_2, m_data_in[1]);
    check("locked_mask", locked_mask, {m_locked[1], m_locked[0]});
    @(posedge Clk); #1;
    check("idle_quiet", {write_1, write_2, Lock_1, Lock_2, rsp_valid, req_ready}, 6'b000001);
  endtask

  // Accept a request, reset on the first cycle after acceptance, then release reset.
  task automatic reset_mid(input logic sel, input logic [15:0] data);
    check("rm_req_ready", req_ready, 1);
    req_sel = sel; req_data = data; req_lock = 1'b1; req_valid = 1'b1;
    @(posedge Clk); #1;
    req_valid = 1'b0;
    if (m_locked[sel]) check("rm_in_resp", rsp_valid, 1);
    else check("rm_in_write", sel ? write_2 : write_1, 1);
    resetn = 1'b0;
    #1;
    check_reset_outputs("rm");
    model_reset();
    @(posedge Clk); #1;
    check_reset_outputs("rm_hold");
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_sel = 1'b0; req_data = '0;
    req_lock = 1'b0; rsp_ready = 1'b0;
    model_reset();
    #2;
    check_reset_outputs("por");
    @(posedge Clk); #1;
    resetn = 1'b1;

    do_req(1'b0, 16'hA5A5, 1'b0, 0, 1'b0, 1'b0);
    do_req(1'b1, 16'h1234, 1'b1, 0, 1'b0, 1'b0);
    do_req(1'b1, 16'hFFFF, 1'b0, 0, 1'b0, 1'b0);
    ignore_w1 = 1'b1;
    do_req(1'b0, 16'h00FF, 1'b1, 0, 1'b0, 1'b0);
    ignore_w1 = 1'b0;
    do_req(1'b0, 16'h0F0F, 1'b0, 5, 1'b0, 1'b1);
    do_req(1'b0, 16'h1111, 1'b0, 0, 1'b1, 1'b0);
    reset_mid(1'b0, 16'h2222);
    do_req(1'b1, 16'h3333, 1'b0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      logic s;
      s = 1'($urandom_range(0, 1));
      if (i % 15 == 14) begin
        reset_mid(s, 16'($urandom));
      end else begin
        ignore_w1 = ($urandom_range(0, 7) == 0);
        do_req(s, 16'($urandom), ($urandom_range(0, 3) == 0),
               $urandom_range(0, 3), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
        ignore_w1 = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
